irq_arbiter: RTL and testbench
==============================

// Module: irq_arbiter
// PURPOSE
//  Interrupt controller feeding the program counter's irq1..irq3 inputs. Latches rising edges on
//  NSRC external sources, applies a CPU-written mask, picks the highest-priority pending source
//  and presents it as the 3-bit vector code {irq3,irq2,irq1} = source index + 1. Code 1..7 makes
//  the counter jump to address 2..8. Holds the code until the counter reports entry (inter). Blocks
//  further requests until the counter signals end of interrupt (eirq, produced by RET).
// PARAMETERS
//  NSRC     7   number of interrupt sources, 1..7 (code = index+1 must fit 3 bits)
//  TIMEOUT  16  cycles REQ may wait for inter before abandoning (only with IRQC_TIMEOUT_EN)
// PORTS
//  clk    in   1     system clock
//  rst    in   1     synchronous active-high reset
//  src    in   NSRC  interrupt sources, rising-edge sensitive
//  we     in   1     register write strobe
//  waddr  in   2     0: mask, 1: clear pending (write-1-to-clear), 2: software set pending
//  wdata  in   8     write data, bits [NSRC-1:0] used
//  raddr  in   2     0: mask, 1: pending, 2: status {err,state[1:0],vec[2:0]}
//  rdata  out  8     combinational read of raddr
//  inter  in   1     counter is inside interrupt service
//  eirq   in   1     end-of-interrupt pulse from counter (RET)
//  irq1   out  1     vector code bit 0
//  irq2   out  1     vector code bit 1
//  irq3   out  1     vector code bit 2
//  busy   out  1     state != IDLE
// BEHAVIOUR
//  - Reset: mask=0, pending=0, src_d=0, state=IDLE, vec=0, irq1..3=0, busy=0, err=0, timer=0.
//    Reset mid-request or mid-service drops all to these values at the reset edge, no handshake.
//  - Edge detect: src_d <= src each cycle. pending[i] sets on src[i] & ~src_d[i].
//    Pending visible 1 cycle after the sampling edge.
//  - Pending set (edge or waddr 2) and W1C clear on the same bit in the same cycle: set wins.
//  - Mask gates arbitration only. Masked edges still latch into pending.
//  - Arbitration: eligible = pending & mask. Highest index wins. vec = index+1 (3 bits).
//  - FSM, all outputs registered:
//    IDLE: if eligible!=0 -> REQ; vec <= winner code; irq{3,2,1} <= vec.
//    REQ: code held stable; winner not re-evaluated.
//      inter=1 -> SERVICE; pending[vec-1] cleared; irq{3,2,1} <= 0.
//      eirq ignored in REQ.
//    SERVICE: irq outputs 0; new edges still latch pending. No nesting.
//      eirq=1 -> IDLE; vec <= 0.
//    Re-arbitration happens in the cycle after returning to IDLE, so back-to-back requests are
//    separated by at least 1 idle cycle.
//  - inter=1 while IDLE (e.g. exception path) suppresses leaving IDLE until inter=0.
//  - Latency: src rise sampled at edge N -> pending at N+1 -> irq code at N+2.
//  - W1C on a bit currently held in REQ does not withdraw the request. The bit clears normally.
// CONFIGURATION
//  IRQC_TIMEOUT_EN defined:
//    REQ counts cycles. After TIMEOUT cycles without inter, go to IDLE with irq=0 and set sticky
//    err. Pending bit is kept, so the request retries. err is cleared by a write to waddr 2 with
//    wdata[7]=1.
//  IRQC_TIMEOUT_EN undefined:
//    REQ waits forever. No timer logic. err reads 0.
// TESTING
//  1. mask=0x7F, pulse src[2] -> irq code 3 two cycles later; inter=1 -> code 0, pending[2]=0;
//     eirq -> busy=0.
//  2. src[1] and src[5] rise same cycle -> code 6. After eirq, code 2 follows one idle cycle later.
//  3. mask=0x00, pulse src[4] -> pending=0x10, no request. Write mask=0x10 -> code 5 next cycle.
//  4. Same cycle: W1C bit 3 and src[3] rising edge -> pending[3]=1.
//     Software set 0x01 with mask=0x01 -> code 1.
//  5. rst asserted during SERVICE -> next cycle all outputs 0, pending 0, state IDLE.
//     Releasing rst with src held high raises no interrupt.
//  6. IRQC_TIMEOUT_EN, TIMEOUT=16: request with inter held 0 -> code drops after 16 cycles,
//     err=1, request reissued.

Source files
------------

// File: rtl/irq_arbiter.sv
// irq_arbiter
//   Interrupt controller for the program counter's irq1..irq3 inputs. Rising
//   edges on NSRC sources latch into a pending register. The highest-index
//   pending source that is not masked wins arbitration. Its code (index + 1) is
//   driven on {irq3,irq2,irq1} until the counter acknowledges with inter.
//   Further requests are blocked until the counter returns with eirq.
//
//   Register map (write):  0 mask, 1 clear pending (W1C), 2 set pending
//   Register map (read):   0 mask, 1 pending, 2 status {err, state[1:0], vec[2:0]}
//
//   Optional feature: define IRQC_TIMEOUT_EN to abandon a request that is not
//   acknowledged within TIMEOUT cycles. An abandoned request sets a sticky err
//   flag and is retried from pending. A write to address 2 with wdata[7]=1
//   clears err. Without the macro, REQ waits forever and err reads 0.
module irq_arbiter #(
  parameter int NSRC    = 7,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src,
  input  logic            we,
  input  logic [1:0]      waddr,
  input  logic [7:0]      wdata,
  input  logic [1:0]      raddr,
  output logic [7:0]      rdata,
  input  logic            inter,
  input  logic            eirq,
  output logic            irq1,
  output logic            irq2,
  output logic            irq3,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  localparam logic [1:0] ADDR_MASK = 2'd0;
  localparam logic [1:0] ADDR_CLR  = 2'd1;
  localparam logic [1:0] ADDR_SET  = 2'd2;
  localparam logic [1:0] ADDR_STAT = 2'd2;

  // Architectural state
  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] src_prev_q, src_prev_d;
  state_e          state_q, state_d;
  logic [2:0]      vec_q, vec_d;
  logic [2:0]      irq_q, irq_d;
  logic            busy_q, busy_d;

  // Combinational helpers
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] wr_clr_bits;
  logic [NSRC-1:0] wr_set_bits;
  logic [NSRC-1:0] svc_clr;
  logic [NSRC-1:0] eligible;
  logic [2:0]      win_code;
  logic            err;

  // wdata[7] only matters with the timeout feature; bits above NSRC never do.
  logic unused_wdata;
  assign unused_wdata = ^wdata;

`ifdef IRQC_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d;
  logic          err_clr;

  assign err_clr = we && (waddr == ADDR_SET) && wdata[7];
  assign err     = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign err            = 1'b0;
`endif

  // Decode register writes and detect source rising edges.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_clr_bits = '0;
    wr_set_bits = '0;
    mask_d      = mask_q;
    if (we) begin
      case (waddr)
        ADDR_MASK: mask_d      = wdata[NSRC-1:0];
        ADDR_CLR:  wr_clr_bits = wdata[NSRC-1:0];
        ADDR_SET:  wr_set_bits = wdata[NSRC-1:0];
        default:   ;
      endcase
    end
    rise       = src & ~src_prev_q;
    src_prev_d = src;
  end

  // Fixed-priority arbitration: the highest eligible index wins, code = index + 1.
  always_comb begin
    eligible = pend_q & mask_q;
    win_code = 3'd0;
    for (int i = 0; i < NSRC; i++) begin
      if (eligible[i]) win_code = 3'(i + 1);
    end
  end

  // Request / service sequencer: next state, held vector and registered irq code.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    irq_d   = irq_q;
    svc_clr = '0;
`ifdef IRQC_TIMEOUT_EN
    timer_d = timer_q;
    err_d   = err_q;
    if (err_clr) err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // inter while idle (exception path) holds off new requests.
        if (!inter && (eligible != '0)) begin
          state_d = REQ;
          vec_d   = win_code;
          irq_d   = win_code;
`ifdef IRQC_TIMEOUT_EN
          timer_d = '0;
`endif
        end
      end
      REQ: begin
        // The code stays frozen; eirq has no meaning before entry.
        if (inter) begin
          state_d = SERVICE;
          irq_d   = 3'd0;
          for (int i = 0; i < NSRC; i++) begin
            if (vec_q == 3'(i + 1)) svc_clr[i] = 1'b1;
          end
        end
`ifdef IRQC_TIMEOUT_EN
        else if (timer_q == TW'(TIMEOUT - 1)) begin
          // Abandon the request; its pending bit stays set so it retries.
          state_d = IDLE;
          irq_d   = 3'd0;
          vec_d   = 3'd0;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
`endif
      end
      SERVICE: begin
        irq_d = 3'd0;
        if (eirq) begin
          state_d = IDLE;
          vec_d   = 3'd0;
        end
      end
      default: begin
        state_d = IDLE;
        vec_d   = 3'd0;
        irq_d   = 3'd0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Pending update: clears (W1C and service entry) apply first, sets win ties.
  always_comb begin
    pend_d = (pend_q & ~(wr_clr_bits | svc_clr)) | rise | wr_set_bits;
  end

  // Combinational register read port.
  always_comb begin
    case (raddr)
      ADDR_MASK: rdata = 8'(mask_q);
      ADDR_CLR:  rdata = 8'(pend_q);
      ADDR_STAT: rdata = {2'b00, err, state_q, vec_q};
      default:   rdata = 8'h00;
    endcase
  end

  // State registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q     <= '0;
      pend_q     <= '0;
      src_prev_q <= '0;
      state_q    <= IDLE;
      vec_q      <= 3'd0;
      irq_q      <= 3'd0;
      busy_q     <= 1'b0;
    end else begin
      mask_q     <= mask_d;
      pend_q     <= pend_d;
      src_prev_q <= src_prev_d;
      state_q    <= state_d;
      vec_q      <= vec_d;
      irq_q      <= irq_d;
      busy_q     <= busy_d;
    end
  end

`ifdef IRQC_TIMEOUT_EN
  // Request timeout counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end
`endif

  assign irq1 = irq_q[0];
  assign irq2 = irq_q[1];
  assign irq3 = irq_q[2];
  assign busy = busy_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter
//   Directed scenarios plus randomized traffic for irq_arbiter. A behavioural
//   model tracks mask, pending and the request/service lifecycle with plain
//   integer arithmetic. Every clock, the vector code, busy and the read port
//   are compared against that model. Timeout scenarios build only with
//   IRQC_TIMEOUT_EN.
module tb_irq_arbiter;

  localparam int NSRC    = 7;
  localparam int TIMEOUT = 16;
  localparam int ALL     = (1 << NSRC) - 1;

  logic            clk;
  logic            rst;
  logic [NSRC-1:0] src;
  logic            we;
  logic [1:0]      waddr;
  logic [7:0]      wdata;
  logic [1:0]      raddr;
  logic [7:0]      rdata;
  logic            inter;
  logic            eirq;
  logic            irq1;
  logic            irq2;
  logic            irq3;
  logic            busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int m_mask, m_pend, m_prev, m_vec, m_code, m_err, m_wait;
  bit m_busy, m_svc;

  irq_arbiter #(.NSRC(NSRC), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst   (rst),
    .src   (src),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata),
    .inter (inter),
    .eirq  (eirq),
    .irq1  (irq1),
    .irq2  (irq2),
    .irq3  (irq3),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic int code_now();
    return int'({irq3, irq2, irq1});
  endfunction

  // One clock of the reference model, evaluated from the inputs present at the edge.
  function automatic void model_step();
    int rise, set_bits, clr_bits, elig, nxt_mask;
    if (rst) begin
      m_mask = 0; m_pend = 0; m_prev = 0; m_vec = 0; m_code = 0;
      m_err  = 0; m_wait = 0; m_busy = 0; m_svc = 0;
    end else begin
      rise     = int'(src) & ~m_prev & ALL;
      set_bits = rise;
      clr_bits = 0;
      nxt_mask = m_mask;
      if (we) begin
        if (waddr == 2'd0) nxt_mask = int'(wdata) & ALL;
        if (waddr == 2'd1) clr_bits = int'(wdata) & ALL;
        if (waddr == 2'd2) set_bits = set_bits | (int'(wdata) & ALL);
`ifdef IRQC_TIMEOUT_EN
        if (waddr == 2'd2 && wdata[7]) m_err = 0;
`endif
      end
      elig = m_pend & m_mask;
      if (!m_busy) begin
        if (!inter && elig != 0) begin
          // Code of the highest set bit = bit length of the eligible set.
          m_vec = 0;
          while ((elig >> m_vec) != 0) m_vec++;
          m_code = m_vec;
          m_busy = 1;
          m_svc  = 0;
          m_wait = 0;
        end
      end else if (!m_svc) begin
        if (inter) begin
          clr_bits = clr_bits | (1 << (m_vec - 1));
          m_code   = 0;
          m_svc    = 1;
        end
`ifdef IRQC_TIMEOUT_EN
        else begin
          m_wait++;
          if (m_wait == TIMEOUT) begin
            m_busy = 0; m_code = 0; m_vec = 0; m_err = 1;
          end
        end
`endif
      end else if (eirq) begin
        m_busy = 0;
        m_svc  = 0;
        m_vec  = 0;
      end
      m_pend = (m_pend & ~clr_bits) | set_bits;
      m_mask = nxt_mask;
      m_prev = int'(src);
    end
  endfunction

  function automatic int model_read(input int a);
    int st;
    st = m_busy ? (m_svc ? 2 : 1) : 0;
    case (a)
      0:       return m_mask;
      1:       return m_pend;
      2:       return (m_err << 5) | (st << 3) | m_vec;
      default: return 0;
    endcase
  endfunction

  // Advance one clock and compare all observable outputs against the model.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("code", code_now(), m_code);
    check("busy", int'(busy), int'(m_busy));
    check("rdata", int'(rdata), model_read(int'(raddr)));
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output int v);
    raddr = a;
    #1;
    v = int'(rdata);
  endtask

  // Acknowledge the current request, spend a cycle in service, then return.
  task automatic serve();
    inter = 1'b1; tick(); inter = 1'b0;
    tick();
    eirq = 1'b1; tick(); eirq = 1'b0;
  endtask

  initial begin
    int v;
    int cnt;
    rst = 1'b1; src = '0; we = 1'b0; waddr = 2'd0; wdata = 8'h00;
    raddr = 2'd0; inter = 1'b0; eirq = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_code", code_now(), 0);
    check("rst_busy", int'(busy), 0);
    for (int a = 0; a < 3; a++) begin
      rd(2'(a), v);
      check("rst_reg", v, 0);
    end

    // 1: single source, latency, entry clears pending, eirq frees
    wr(2'd0, 8'h7F);
    src = 7'h04; tick();
    check("t1_code_early", code_now(), 0);
    src = '0; tick();
    check("t1_code", code_now(), 3);
    tick();
    check("t1_code_held", code_now(), 3);
    inter = 1'b1; tick(); inter = 1'b0;
    check("t1_code_entry", code_now(), 0);
    rd(2'd1, v);
    check("t1_pend_clr", v, 0);
    tick();
    eirq = 1'b1; tick(); eirq = 1'b0;
    check("t1_busy_done", int'(busy), 0);

    // 2: simultaneous sources, priority, one idle cycle between requests
    src = 7'h22; tick();
    src = '0; tick();
    check("t2_code_hi", code_now(), 6);
    inter = 1'b1; tick(); inter = 1'b0;
    tick();
    eirq = 1'b1; tick(); eirq = 1'b0;
    check("t2_idle_gap", code_now(), 0);
    check("t2_idle_busy", int'(busy), 0);
    tick();
    check("t2_code_lo", code_now(), 2);
    serve();

    // 3: masked edge still latches; unmasking raises the request
    wr(2'd0, 8'h00);
    src = 7'h10; tick();
    src = '0; tick();
    rd(2'd1, v);
    check("t3_pend", v, 'h10);
    check("t3_no_req", code_now(), 0);
    wr(2'd0, 8'h10);
    check("t3_code_wait", code_now(), 0);
    tick();
    check("t3_code", code_now(), 5);
    serve();

    // 4: set beats W1C on the same bit; software set raises a request
    wr(2'd0, 8'h00);
    wr(2'd2, 8'h08);
    src = 7'h08; we = 1'b1; waddr = 2'd1; wdata = 8'h08;
    tick();
    we = 1'b0;
    rd(2'd1, v);
    check("t4_set_wins", (v >> 3) & 1, 1);
    src = '0;
    wr(2'd1, 8'h7F);
    rd(2'd1, v);
    check("t4_w1c", v, 0);
    wr(2'd0, 8'h01);
    wr(2'd2, 8'h01);
    tick();
    check("t4_code", code_now(), 1);
    inter = 1'b1; tick(); inter = 1'b0;

    // 5: reset during service; release with sources held high
    rst = 1'b1; src = 7'h7F;
    tick();
    check("t5_code", code_now(), 0);
    check("t5_busy", int'(busy), 0);
    for (int a = 0; a < 3; a++) begin
      rd(2'(a), v);
      check("t5_reg", v, 0);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_no_irq", code_now(), 0);
    end
    src = '0;
    tick();

`ifdef IRQC_TIMEOUT_EN
    // 6: unacknowledged request times out, sets err and retries
    wr(2'd1, 8'h7F);
    wr(2'd0, 8'h7F);
    wr(2'd2, 8'h40);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (code_now() == 7) cnt++;
      else if (cnt > 0) break;
    end
    check("t6_cycles", cnt, TIMEOUT);
    rd(2'd2, v);
    check("t6_err", (v >> 5) & 1, 1);
    tick();
    check("t6_retry", code_now(), 7);
    wr(2'd2, 8'h80);
    rd(2'd2, v);
    check("t6_err_clr", (v >> 5) & 1, 0);
    serve();
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 149) == 0);
      src   = NSRC'($urandom);
      we    = ($urandom_range(0, 3) == 0);
      waddr = 2'($urandom);
      wdata = 8'($urandom);
      raddr = 2'($urandom);
      inter = ($urandom_range(0, 3) == 0);
      eirq  = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
